mdio_master_gen: RTL and testbench

- Parametrised successor to the single-rate MDIO transaction generator.
- Runs a complete IEEE 802.3 Clause 22 management frame: preamble, ST, OP, PHYAD, REGAD, TA and DATA.
- MDC rate and preamble length are programmable, and the block has busy/error handshakes.
- Sits between the management register block and the MDIO pad (tri-state handled at the pad via mdio_oe). Single clock domain; MDC is derived from clk.

---
 rtl/mdio_master_gen_if.sv | 40 ++++
 rtl/mdio_master_gen.sv | 235 +++++++++++++++++++++++
 tb/tb_mdio_master_gen.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_master_gen_if.sv
// mdio_master_gen_if
// Request/response bus between the management register block and the MDIO
// frame generator.
//   master modport : register block side (issues requests, reads results)
//   slave modport  : frame generator side
// Signals:
//   mdio_start : request strobe, honoured only while busy=0
//   t_data     : 32-bit Clause 22 frame {ST, OP, PHYAD, REGAD, TA, DATA}
//   rd_data    : read result, valid when data_rdy pulses
//   data_rdy   : one-cycle pulse, rd_data updated
//   busy       : transaction in progress
//   frame_err  : one-cycle pulse, request rejected
interface mdio_master_gen_if #(
  parameter int DATA_W = 16
);
  logic              mdio_start;
  logic [31:0]       t_data;
  logic [DATA_W-1:0] rd_data;
  logic              data_rdy;
  logic              busy;
  logic              frame_err;

  modport master (
    output mdio_start,
    output t_data,
    input  rd_data,
    input  data_rdy,
    input  busy,
    input  frame_err
  );

  modport slave (
    input  mdio_start,
    input  t_data,
    output rd_data,
    output data_rdy,
    output busy,
    output frame_err
  );
endinterface

// File: rtl/mdio_master_gen.sv
// mdio_master_gen
// Runs one complete IEEE 802.3 Clause 22 management frame per request:
// preamble, ST, OP, PHYAD, REGAD, TA and DATA. MDC is derived from clk by a
// programmable divider; the pad tri-state is handled outside via mdio_oe.
//
// Parameters:
//   CLK_DIV      : clk cycles per MDC half-period (>= 1)
//   PREAMBLE_LEN : number of preamble '1' bits (0..63, 0 = no preamble)
//   DATA_W       : width of the data field / rd_data (16 for Clause 22)
//
// Ports:
//   clk      : system clock
//   reset    : asynchronous, active-low reset
//   bus      : request/response bus (slave modport of mdio_master_gen_if)
//   mdio_in  : MDIO pad input
//   mdc      : management clock
//   mdio_out : MDIO drive value
//   mdio_oe  : MDIO output enable (1 = master drives)
//
// Optional feature macro: MDIO_CLAUSE45_EN
//   When defined, ST=00 (Clause 45) frames are accepted as well: OP 00/01 are
//   driven like a write, OP 11/10 are handled like a read.
module mdio_master_gen #(
  parameter int CLK_DIV      = 2,
  parameter int PREAMBLE_LEN = 32,
  parameter int DATA_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  mdio_master_gen_if.slave bus,
  input  logic             mdio_in,
  output logic             mdc,
  output logic             mdio_out,
  output logic             mdio_oe
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0] PRE_LAST  = 6'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
  localparam logic [5:0] HDR_LAST  = 6'd13;
  localparam logic [5:0] TA_LAST   = 6'd1;
  localparam logic [5:0] DATA_LAST = 6'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    PREAMBLE,
    HEADER,
    TA,
    DATA,
    DONE
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic [31:0]       tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rd_data_q;
  logic              data_rdy_q;
  logic              busy_q;
  logic              frame_err_q;
  logic              is_read;

  logic running;
  logic tick;
  logic rise;
  logic fall;
  logic frame_ok;
  logic frame_rd;

  assign bus.rd_data   = rd_data_q;
  assign bus.data_rdy  = data_rdy_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;

  // MDC only runs while bits are on the wire; a tick is the divider
  // rolling over, and it is a rise or a fall depending on the current mdc.
  assign running = (state == PREAMBLE) || (state == HEADER) ||
                   (state == TA) || (state == DATA);
  assign tick    = running && (div_cnt == DIV_LAST);
  assign rise    = tick && !mdc;
  assign fall    = tick && mdc;

  // Frame classification from the latched ST/OP fields.
  always_comb begin
    frame_ok = 1'b0;
    frame_rd = 1'b0;
    if (tx_sr[31:30] == 2'b01) begin
      frame_ok = (tx_sr[29:28] == 2'b10) || (tx_sr[29:28] == 2'b01);
      frame_rd = (tx_sr[29:28] == 2'b10);
    end
`ifdef MDIO_CLAUSE45_EN
    else if (tx_sr[31:30] == 2'b00) begin
      frame_ok = 1'b1;
      frame_rd = tx_sr[29];
    end
`else
`endif
  end

  // tx_sr doubles as the latched frame: bit 31 is always the bit currently
  // on the wire, so the next bit to drive at a fall is tx_sr[30].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      rd_data_q   <= '0;
      data_rdy_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      is_read     <= 1'b0;
      mdc         <= 1'b0;
      mdio_out    <= 1'b0;
      mdio_oe     <= 1'b0;
    end else begin
      data_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (running) begin
        if (tick) begin
          div_cnt <= '0;
          mdc     <= ~mdc;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (bus.mdio_start) begin
            tx_sr  <= bus.t_data;
            busy_q <= 1'b1;
            state  <= CHECK;
          end
        end

        CHECK: begin
          is_read <= frame_rd;
          rx_sr   <= '0;
          bit_cnt <= '0;
          div_cnt <= '0;
          mdc     <= 1'b0;
          if (!frame_ok) begin
            frame_err_q <= 1'b1;
            state       <= DONE;
          end else if (PREAMBLE_LEN > 0) begin
            mdio_oe  <= 1'b1;
            mdio_out <= 1'b1;
            state    <= PREAMBLE;
          end else begin
            mdio_oe  <= 1'b1;
            mdio_out <= tx_sr[31];
            state    <= HEADER;
          end
        end

        PREAMBLE: begin
          if (fall) begin
            if (bit_cnt == PRE_LAST) begin
              bit_cnt  <= '0;
              mdio_out <= tx_sr[31];
              state    <= HEADER;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end

        HEADER: begin
          if (fall) begin
            tx_sr <= {tx_sr[30:0], 1'b0};
            if (bit_cnt == HDR_LAST) begin
              // A read releases the line for the turnaround.
              bit_cnt  <= '0;
              mdio_oe  <= ~is_read;
              mdio_out <= ~is_read & tx_sr[30];
              state    <= TA;
            end else begin
              bit_cnt  <= bit_cnt + 6'd1;
              mdio_out <= tx_sr[30];
            end
          end
        end

        TA: begin
          if (fall) begin
            tx_sr    <= {tx_sr[30:0], 1'b0};
            mdio_out <= ~is_read & tx_sr[30];
            if (bit_cnt == TA_LAST) begin
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end

        DATA: begin
          if (rise && is_read) begin
            rx_sr <= {rx_sr[DATA_W-2:0], mdio_in};
          end
          if (fall) begin
            tx_sr    <= {tx_sr[30:0], 1'b0};
            mdio_out <= ~is_read & tx_sr[30];
            if (bit_cnt == DATA_LAST) begin
              // The last rise already shifted in the final bit.
              bit_cnt  <= '0;
              mdio_oe  <= 1'b0;
              mdio_out <= 1'b0;
              if (is_read) begin
                rd_data_q  <= rx_sr;
                data_rdy_q <= 1'b1;
              end
              state <= DONE;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end

        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master_gen.sv
// tb_mdio_master_gen
// Self-checking bench for mdio_master_gen. Instance A uses the default
// parameters (CLK_DIV=2, PREAMBLE_LEN=32); instance B uses CLK_DIV=1,
// PREAMBLE_LEN=0. Expected wire bits and read words are pushed to queues when
// a request is issued and compared against what the DUT produced.
// Honours MDIO_CLAUSE45_EN for the ST=00 expectation.
module tb_mdio_master_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mdio_in_a = 1'b0;
  logic mdio_in_b = 1'b0;
  logic mdc_a, out_a, oe_a;
  logic mdc_b, out_b, oe_b;

  int errors = 0;
  int checks = 0;

  logic [1:0]  exp_q[$];
  logic [1:0]  obs_q[$];
  logic [15:0] exp_rd_q[$];
  logic [15:0] obs_rd_q[$];
  logic [5:0]  abort_snap;
  logic [15:0] abort_rd;
  logic [15:0] rd_prev_a = 16'h0000;

  mdio_master_gen_if #(.DATA_W(16)) bus_a ();
  mdio_master_gen_if #(.DATA_W(16)) bus_b ();

  mdio_master_gen #(.CLK_DIV(2), .PREAMBLE_LEN(32), .DATA_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .mdio_in(mdio_in_a),
    .mdc(mdc_a), .mdio_out(out_a), .mdio_oe(oe_a)
  );

  mdio_master_gen #(.CLK_DIV(1), .PREAMBLE_LEN(0), .DATA_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .mdio_in(mdio_in_b),
    .mdc(mdc_b), .mdio_out(out_b), .mdio_oe(oe_b)
  );

  always #5 clk = ~clk;

  // Reference wire content for one valid frame: {oe, out} per MDC period.
  task automatic push_expected(input logic [31:0] td, input int pre_len,
                               input bit rd, input logic [15:0] phy_word);
    for (int i = 0; i < pre_len; i++) exp_q.push_back(2'b11);
    for (int b = 31; b >= 18; b--) exp_q.push_back({1'b1, td[b]});
    for (int b = 17; b >= 0; b--) exp_q.push_back(rd ? 2'b00 : {1'b1, td[b]});
    if (rd) exp_rd_q.push_back(phy_word);
  endtask

  task automatic drain(output logic [255:0] ov, output logic [255:0] ev,
                       output int on, output int en);
    ov = '0;
    ev = '0;
    on = obs_q.size();
    en = exp_q.size();
    for (int i = 0; i < 128 && obs_q.size() > 0; i++) ov[2*i +: 2] = obs_q.pop_front();
    for (int i = 0; i < 128 && exp_q.size() > 0; i++) ev[2*i +: 2] = exp_q.pop_front();
    obs_q.delete();
    exp_q.delete();
  endtask

  // Issues one request on instance sel (0=A, 1=B), acts as the PHY and
  // records what appears on the wire until busy drops (bounded).
  task automatic applyStimulus(input bit sel, input logic [31:0] td,
                               input logic [15:0] phy_word, input int pre_len,
                               input bit skip_start, input int mid_at,
                               input logic [31:0] mid_td, input int abort_at,
                               output int n_cycles, output int rdy_cnt,
                               output int rdy_at, output int err_cnt,
                               output int rises, output bit oe_seen);
    logic prev_mdc, cur_mdc, busy_v, nb;
    int idx;
    n_cycles = 0; rdy_cnt = 0; rdy_at = -1; err_cnt = 0; rises = 0; oe_seen = 1'b0;
    prev_mdc = 1'b0;
    if (!skip_start) begin
      @(negedge clk);
      if (sel) begin bus_b.t_data = td; bus_b.mdio_start = 1'b1; end
      else begin bus_a.t_data = td; bus_a.mdio_start = 1'b1; end
    end
    busy_v = 1'b1;
    while (busy_v && n_cycles < 2000) begin
      @(posedge clk);
      #1;
      n_cycles++;
      if (n_cycles == 1) begin bus_a.mdio_start = 1'b0; bus_b.mdio_start = 1'b0; end
      if (abort_at > 0 && n_cycles == abort_at) begin
        reset = 1'b0;
        #1;
        abort_snap = sel ? {mdc_b, out_b, oe_b, bus_b.data_rdy, bus_b.busy, bus_b.frame_err}
                         : {mdc_a, out_a, oe_a, bus_a.data_rdy, bus_a.busy, bus_a.frame_err};
        abort_rd = sel ? bus_b.rd_data : bus_a.rd_data;
        break;
      end
      if (mid_at > 0 && n_cycles == mid_at) begin
        if (sel) begin bus_b.t_data = mid_td; bus_b.mdio_start = 1'b1; end
        else begin bus_a.t_data = mid_td; bus_a.mdio_start = 1'b1; end
      end
      cur_mdc = sel ? mdc_b : mdc_a;
      if (cur_mdc && !prev_mdc) begin
        obs_q.push_back(sel ? {oe_b, out_b} : {oe_a, out_a});
        rises++;
      end
      if (!cur_mdc && prev_mdc) begin
        idx = rises - (pre_len + 16);
        nb = (idx >= 0 && idx < 16) ? phy_word[4'(15 - idx)] : 1'($urandom_range(0, 1));
        if (sel) mdio_in_b = nb; else mdio_in_a = nb;
      end
      prev_mdc = cur_mdc;
      if (sel ? oe_b : oe_a) oe_seen = 1'b1;
      if (sel ? bus_b.data_rdy : bus_a.data_rdy) begin
        rdy_cnt++;
        rdy_at = n_cycles;
        obs_rd_q.push_back(sel ? bus_b.rd_data : bus_a.rd_data);
      end
      if (sel ? bus_b.frame_err : bus_a.frame_err) err_cnt++;
      busy_v = sel ? bus_b.busy : bus_a.busy;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({mdc_a, out_a, oe_a, bus_a.data_rdy, bus_a.busy, bus_a.frame_err, bus_a.rd_data} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL reset_a: got %h expected 0", {mdc_a, out_a, oe_a, bus_a.data_rdy, bus_a.busy, bus_a.frame_err, bus_a.rd_data});
    end
    checks++;
    if ({mdc_b, out_b, oe_b, bus_b.data_rdy, bus_b.busy, bus_b.frame_err, bus_b.rd_data} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL reset_b: got %h expected 0", {mdc_b, out_b, oe_b, bus_b.data_rdy, bus_b.busy, bus_b.frame_err, bus_b.rd_data});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mdc_a, oe_a, bus_a.busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %b expected 000", {mdc_a, oe_a, bus_a.busy});
    end
  endtask

  task automatic test_write();
    int nc, rc, ra, ec, rs, on, en;
    bit os;
    logic [255:0] ov, ev;
    push_expected(32'h5086_A5A5, 32, 1'b0, 16'h0000);
    applyStimulus(1'b0, 32'h5086_A5A5, 16'h0000, 32, 1'b0, 0, 32'h0, 0, nc, rc, ra, ec, rs, os);
    drain(ov, ev, on, en);
    checks++;
    if (ov !== ev || on != en) begin
      errors++;
      $display("[TB] FAIL write_bits: got %0d bits %h expected %0d bits %h", on, ov, en, ev);
    end
    checks++;
    if (nc != 259) begin errors++; $display("[TB] FAIL write_latency: got %0d expected 259", nc); end
    checks++;
    if (rc != 0 || ec != 0) begin errors++; $display("[TB] FAIL write_pulses: got rdy=%0d err=%0d expected 0/0", rc, ec); end
    checks++;
    if (bus_a.rd_data !== rd_prev_a) begin
      errors++;
      $display("[TB] FAIL write_rd_hold: got %h expected %h", bus_a.rd_data, rd_prev_a);
    end
    obs_rd_q.delete();
  endtask

  task automatic test_read();
    int nc, rc, ra, ec, rs, on, en;
    bit os;
    logic [255:0] ov, ev;
    logic [15:0] got, exp;
    push_expected(32'h6086_0000, 32, 1'b1, 16'hBEEF);
    applyStimulus(1'b0, 32'h6086_0000, 16'hBEEF, 32, 1'b0, 0, 32'h0, 0, nc, rc, ra, ec, rs, os);
    drain(ov, ev, on, en);
    checks++;
    if (ov !== ev || on != en) begin
      errors++;
      $display("[TB] FAIL read_bits: got %0d bits %h expected %0d bits %h", on, ov, en, ev);
    end
    got = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : 16'hxxxx;
    exp = exp_rd_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL read_data: got %h expected %h", got, exp); end
    checks++;
    if (rc != 1 || ra != nc - 1) begin
      errors++;
      $display("[TB] FAIL read_rdy_pulse: got count=%0d at=%0d expected 1 at %0d", rc, ra, nc - 1);
    end
    checks++;
    if (nc != 259) begin errors++; $display("[TB] FAIL read_latency: got %0d expected 259", nc); end
    rd_prev_a = 16'hBEEF;
    obs_rd_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic test_invalid();
    int nc, rc, ra, ec, rs;
    bit os;
    logic [31:0] bad_frames [2];
    bad_frames[0] = 32'h4000_0000;
    bad_frames[1] = 32'hD000_0000;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, bad_frames[k], 16'h0000, 32, 1'b0, 0, 32'h0, 0, nc, rc, ra, ec, rs, os);
      checks++;
      if (ec != 1 || nc != 3) begin
        errors++;
        $display("[TB] FAIL invalid_err_%0d: got err=%0d busy_end=%0d expected 1/3", k, ec, nc);
      end
      checks++;
      if (rs != 0 || os || rc != 0) begin
        errors++;
        $display("[TB] FAIL invalid_quiet_%0d: got rises=%0d oe=%0d rdy=%0d expected 0/0/0", k, rs, os, rc);
      end
    end
    checks++;
    if (bus_a.rd_data !== rd_prev_a) begin
      errors++;
      $display("[TB] FAIL invalid_rd_hold: got %h expected %h", bus_a.rd_data, rd_prev_a);
    end
    obs_q.delete();
    obs_rd_q.delete();
  endtask

  task automatic test_back_to_back();
    int nc, rc, ra, ec, rs, on, en;
    bit os;
    logic [255:0] ov, ev;
    logic [15:0] got, exp;
    push_expected(32'h5123_1234, 32, 1'b0, 16'h0000);
    applyStimulus(1'b0, 32'h5123_1234, 16'h0000, 32, 1'b0, 20, 32'h6086_0000, 0, nc, rc, ra, ec, rs, os);
    drain(ov, ev, on, en);
    checks++;
    if (ov !== ev || on != en) begin
      errors++;
      $display("[TB] FAIL b2b_first_bits: got %0d bits %h expected %0d bits %h", on, ov, en, ev);
    end
    checks++;
    if (nc != 259 || bus_a.rd_data !== rd_prev_a) begin
      errors++;
      $display("[TB] FAIL b2b_first_done: got cycles=%0d rd=%h expected 259 rd=%h", nc, bus_a.rd_data, rd_prev_a);
    end
    push_expected(32'h6086_0000, 32, 1'b1, 16'h1234);
    applyStimulus(1'b0, 32'h6086_0000, 16'h1234, 32, 1'b1, 0, 32'h0, 0, nc, rc, ra, ec, rs, os);
    drain(ov, ev, on, en);
    checks++;
    if (ov !== ev || on != en || nc != 259) begin
      errors++;
      $display("[TB] FAIL b2b_second_frame: got %0d bits %h cycles=%0d expected %0d bits %h cycles=259", on, ov, nc, en, ev);
    end
    got = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : 16'hxxxx;
    exp = exp_rd_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL b2b_read_data: got %h expected %h", got, exp); end
    rd_prev_a = 16'h1234;
    obs_rd_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic test_reset_abort();
    int nc, rc, ra, ec, rs, on, en;
    bit os;
    logic [255:0] ov, ev;
    logic [15:0] got, exp;
    applyStimulus(1'b0, 32'h6086_0000, 16'hCAFE, 32, 1'b0, 0, 32'h0, 200, nc, rc, ra, ec, rs, os);
    checks++;
    if (abort_snap !== 6'd0 || abort_rd !== 16'h0000 || rc != 0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got %b rd=%h rdy=%0d expected 000000 rd=0000 rdy=0", abort_snap, abort_rd, rc);
    end
    obs_q.delete();
    obs_rd_q.delete();
    rd_prev_a = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_expected(32'h6086_0000, 32, 1'b1, 16'hA5C3);
    applyStimulus(1'b0, 32'h6086_0000, 16'hA5C3, 32, 1'b0, 0, 32'h0, 0, nc, rc, ra, ec, rs, os);
    drain(ov, ev, on, en);
    checks++;
    if (ov !== ev || on != en) begin
      errors++;
      $display("[TB] FAIL abort_next_bits: got %0d bits %h expected %0d bits %h", on, ov, en, ev);
    end
    got = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : 16'hxxxx;
    exp = exp_rd_q.pop_front();
    checks++;
    if (got !== exp || rc != 1) begin
      errors++;
      $display("[TB] FAIL abort_next_read: got %h rdy=%0d expected %h rdy=1", got, rc, exp);
    end
    obs_rd_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic test_fast_read();
    int nc, rc, ra, ec, rs, on, en;
    bit os;
    logic [255:0] ov, ev;
    logic [15:0] got, exp;
    push_expected(32'h6086_0000, 0, 1'b1, 16'h1357);
    applyStimulus(1'b1, 32'h6086_0000, 16'h1357, 0, 1'b0, 0, 32'h0, 0, nc, rc, ra, ec, rs, os);
    drain(ov, ev, on, en);
    checks++;
    if (ov !== ev || on != en) begin
      errors++;
      $display("[TB] FAIL fast_bits: got %0d bits %h expected %0d bits %h", on, ov, en, ev);
    end
    checks++;
    if (nc != 67 || rs != 32) begin
      errors++;
      $display("[TB] FAIL fast_timing: got cycles=%0d rises=%0d expected 67/32", nc, rs);
    end
    got = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : 16'hxxxx;
    exp = exp_rd_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL fast_read_data: got %h expected %h", got, exp); end
    obs_rd_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic test_clause45();
    int nc, rc, ra, ec, rs, on, en;
    bit os;
    logic [255:0] ov, ev;
    logic [15:0] got, exp;
`ifdef MDIO_CLAUSE45_EN
    push_expected(32'h3000_0000, 0, 1'b1, 16'h2468);
    applyStimulus(1'b1, 32'h3000_0000, 16'h2468, 0, 1'b0, 0, 32'h0, 0, nc, rc, ra, ec, rs, os);
    drain(ov, ev, on, en);
    checks++;
    if (ov !== ev || on != en || ec != 0) begin
      errors++;
      $display("[TB] FAIL c45_bits: got %0d bits %h err=%0d expected %0d bits %h err=0", on, ov, ec, en, ev);
    end
    got = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : 16'hxxxx;
    exp = exp_rd_q.pop_front();
    checks++;
    if (got !== exp || rc != 1) begin
      errors++;
      $display("[TB] FAIL c45_read: got %h rdy=%0d expected %h rdy=1", got, rc, exp);
    end
`else
    applyStimulus(1'b1, 32'h3000_0000, 16'h2468, 0, 1'b0, 0, 32'h0, 0, nc, rc, ra, ec, rs, os);
    drain(ov, ev, on, en);
    got = 16'h0000;
    exp = 16'h0000;
    checks++;
    if (ec != 1 || nc != 3 || rs != 0 || rc != 0) begin
      errors++;
      $display("[TB] FAIL c45_reject: got err=%0d cycles=%0d rises=%0d rdy=%0d expected 1/3/0/0", ec, nc, rs, rc);
    end
`endif
    obs_rd_q.delete();
    exp_rd_q.delete();
  endtask

  initial begin
    bus_a.mdio_start = 1'b0;
    bus_a.t_data = 32'h0;
    bus_b.mdio_start = 1'b0;
    bus_b.t_data = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_invalid();
    test_back_to_back();
    test_reset_abort();
    test_fast_read();
    test_clause45();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
